// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched, masked, fixed-priority interrupt source with quantum timer
module interrupt_controller #(
   parameter int CHANNELS      = 4,
   parameter int ADDR_WIDTH    = 12,
   parameter int QUANTUM_WIDTH = 16,
   parameter int VECTOR_BASE   = 12'hF00,
   parameter int VECTOR_STRIDE = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           irq,
   input  logic                          maskWrite,
   input  logic [CHANNELS-1:0]           maskData,
   input  logic                          quantumWrite,
   input  logic [QUANTUM_WIDTH-1:0]      quantumData,
   input  logic                          userMode,
   input  logic                          ack,
   input  logic                          eoi,
   output logic                          interruption,
   output logic [$clog2(CHANNELS+1)-1:0] cause,
   output logic [ADDR_WIDTH-1:0]         vector,
   output logic [CHANNELS-1:0]           pending,
   output logic                          busy
);
   localparam int CW = $clog2(CHANNELS+1);

   typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} stateType;

   stateType                 state, nextState;
   logic [CHANNELS-1:0]      prevIrq, mask, eligible, clearBits;
   logic [QUANTUM_WIDTH-1:0] quantum, counter;
   logic                     timerPending, anyEligible, ackTaken, timerClear, timerTick;
   logic [CW-1:0]            winCause;
   logic [ADDR_WIDTH-1:0]    winVector;

   assign interruption = state == REQUEST;
   assign busy         = state == SERVICE;
   assign ackTaken     = state == REQUEST && ack;
   assign timerClear   = ackTaken && cause == CW'(CHANNELS);
   assign clearBits    = ackTaken ? CHANNELS'(1) << cause : '0;
   assign timerTick    = userMode && state == IDLE && quantum != '0;

   // lowest enabled channel wins; the timer only when no channel is eligible
   always_comb begin
      eligible    = pending & mask;
      winCause    = CW'(CHANNELS);
      anyEligible = timerPending;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (eligible[i]) begin
            winCause    = CW'(i);
            anyEligible = 1'b1;
         end
      winVector = ADDR_WIDTH'(VECTOR_BASE + int'(winCause) * VECTOR_STRIDE);
   end

   // next-state: present one request, hold it until ack, then wait for eoi
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    nextState = anyEligible ? REQUEST : IDLE;
         REQUEST: nextState = ack ? SERVICE : REQUEST;
         SERVICE: nextState = eoi ? IDLE : SERVICE;
         default: nextState = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= nextState;

   // edge capture; a new edge beats a simultaneous ack clear
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         prevIrq <= '0;
         pending <= '0;
      end else begin
         prevIrq <= irq;
         pending <= (pending & ~clearBits) | (irq & ~prevIrq);
      end

   // mask register
   always_ff @(posedge clock or negedge reset)
      if (!reset)         mask <= '1;
      else if (maskWrite) mask <= maskData;

   // quantum timer; a write overrides a terminal decrement
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         quantum      <= '0;
         counter      <= '0;
         timerPending <= 1'b0;
      end else begin
         if (quantumWrite) begin
            quantum <= quantumData;
            counter <= quantumData;
         end else if (timerTick)
            counter <= counter == QUANTUM_WIDTH'(1) ? quantum : counter - 1'b1;
         timerPending <= (timerPending && !timerClear) ||
                         (timerTick && !quantumWrite && counter == QUANTUM_WIDTH'(1));
      end

   // latch the winner when leaving IDLE so the presented request stays frozen
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         cause  <= '0;
         vector <= ADDR_WIDTH'(VECTOR_BASE);
      end else if (state == IDLE && anyEligible) begin
         cause  <= winCause;
         vector <= winVector;
      end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed stimulus with a request scoreboard checked by an independent monitor
module tb_interrupt_controller;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  irq = '0;
   logic        maskWrite = 1'b0;
   logic [3:0]  maskData = '0;
   logic        quantumWrite = 1'b0;
   logic [15:0] quantumData = '0;
   logic        userMode = 1'b0;
   logic        ack = 1'b0;
   logic        eoi = 1'b0;
   logic        interruption;
   logic [2:0]  cause;
   logic [11:0] vector;
   logic [3:0]  pending;
   logic        busy;

   typedef struct {int cause; int vector; int cyc;} expType;
   expType expQ[$];
   int     nCompared = 0;
   int     nMismatch = 0;
   int     cyc = 0;
   logic   prevInt = 1'b0;

   interrupt_controller dut (
      .clock(clock), .reset(reset), .irq(irq), .maskWrite(maskWrite), .maskData(maskData),
      .quantumWrite(quantumWrite), .quantumData(quantumData), .userMode(userMode),
      .ack(ack), .eoi(eoi), .interruption(interruption), .cause(cause), .vector(vector),
      .pending(pending), .busy(busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      nCompared++;
      if (got != want) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, want, cyc);
      end
   endtask

   task automatic pushExp(input int c, input int v, input int at);
      expType e;
      e.cause = c;
      e.vector = v;
      e.cyc = at;
      expQ.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic edgeIrq(input logic [3:0] bits);
      irq = bits;
      tick(1);
      irq = '0;
   endtask

   task automatic doAck();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   task automatic doEoi();
      eoi = 1'b1;
      tick(1);
      eoi = 1'b0;
   endtask

   always @(negedge clock) begin
      if (interruption && !prevInt) begin
         if (expQ.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL unexpected_request: got cause %0d vector 0x%0h, expected none at cycle %0d", cause, vector, cyc);
         end else begin
            expType e;
            e = expQ.pop_front();
            check("req_cause", int'(cause), e.cause);
            check("req_vector", int'(vector), e.vector);
            check("req_cycle", cyc, e.cyc);
         end
      end else if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
         nCompared++;
         nMismatch++;
         $display("FAIL missing_request: got none, expected cause %0d by cycle %0d", expQ[0].cause, expQ[0].cyc);
         void'(expQ.pop_front());
      end
      prevInt = interruption;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(2);
      check("rst_interruption", int'(interruption), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cause", int'(cause), 0);
      check("rst_vector", int'(vector), 'hF00);
      check("rst_pending", int'(pending), 0);
      reset = 1'b1;
      tick(2);
      // priority: channels 1 and 2 together
      pushExp(1, 'hF10, cyc + 2);
      edgeIrq(4'b0110);
      tick(1);
      check("prio_int", int'(interruption), 1);
      doAck();
      check("prio_ack_busy", int'(busy), 1);
      check("prio_ack_int", int'(interruption), 0);
      check("prio_ack_pending", int'(pending), 'b0100);
      pushExp(2, 'hF20, cyc + 2);
      doEoi();
      check("prio_eoi_busy", int'(busy), 0);
      tick(1);
      doAck();
      check("prio2_pending", int'(pending), 0);
      doEoi();
      // masking
      maskData = 4'b1110;
      maskWrite = 1'b1;
      tick(1);
      maskWrite = 1'b0;
      edgeIrq(4'b0001);
      tick(3);
      check("mask_pending", int'(pending), 'b0001);
      check("mask_no_int", int'(interruption), 0);
      pushExp(0, 'hF00, cyc + 2);
      maskData = 4'b1111;
      maskWrite = 1'b1;
      tick(1);
      maskWrite = 1'b0;
      tick(1);
      doAck();
      doEoi();
      // freeze: channel 0 arrives while channel 3 is presented
      pushExp(3, 'hF30, cyc + 2);
      edgeIrq(4'b1000);
      tick(1);
      edgeIrq(4'b0001);
      tick(1);
      check("freeze_cause", int'(cause), 3);
      check("freeze_vector", int'(vector), 'hF30);
      check("freeze_pending", int'(pending), 'b1001);
      doAck();
      check("freeze_ack_pending", int'(pending), 'b0001);
      pushExp(0, 'hF00, cyc + 2);
      doEoi();
      tick(1);
      doAck();
      doEoi();
      // timer: quantum 5 in user mode
      userMode = 1'b1;
      quantumData = 16'd5;
      quantumWrite = 1'b1;
      pushExp(4, 'hF40, cyc + 7);
      tick(1);
      quantumWrite = 1'b0;
      tick(6);
      userMode = 1'b0;
      doAck();
      check("timer_busy", int'(busy), 1);
      doEoi();
      tick(20);
      check("timer_kernel_int", int'(interruption), 0);
      check("timer_kernel_pending", int'(pending), 0);
      quantumData = '0;
      quantumWrite = 1'b1;
      tick(1);
      quantumWrite = 1'b0;
      // set wins over ack clear; spurious handshakes
      pushExp(1, 'hF10, cyc + 2);
      edgeIrq(4'b0010);
      tick(1);
      irq = 4'b0010;
      doAck();
      irq = '0;
      check("setwin_pending", int'(pending), 'b0010);
      check("setwin_busy", int'(busy), 1);
      doAck();
      tick(1);
      check("spur_ack_busy", int'(busy), 1);
      check("spur_ack_int", int'(interruption), 0);
      check("spur_ack_pending", int'(pending), 'b0010);
      pushExp(1, 'hF10, cyc + 2);
      doEoi();
      tick(1);
      doAck();
      check("setwin2_pending", int'(pending), 0);
      doEoi();
      doEoi();
      tick(3);
      check("spur_eoi_busy", int'(busy), 0);
      check("spur_eoi_int", int'(interruption), 0);
      // asynchronous reset in SERVICE
      pushExp(1, 'hF10, cyc + 2);
      edgeIrq(4'b0110);
      tick(1);
      doAck();
      edgeIrq(4'b0010);
      tick(1);
      check("prereset_pending", int'(pending), 'b0110);
      check("prereset_busy", int'(busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_pending", int'(pending), 0);
      check("arst_int", int'(interruption), 0);
      check("arst_vector", int'(vector), 'hF00);
      tick(1);
      reset = 1'b1;
      tick(10);
      check("postreset_int", int'(interruption), 0);
      pushExp(2, 'hF20, cyc + 2);
      edgeIrq(4'b0100);
      tick(1);
      doAck();
      doEoi();
      tick(5);
      check("queue_drained", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end
endmodule
